// File: rtl/kami_step_issuer.sv
// kami_step_issuer: debounced push-button to single-cycle
// count_value method calls, with a 3-deep request queue.
module kami_step_issuer #(
  parameter int VALUE_W         = 4,
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int REPEAT_CYCLES   = 6000000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               btn_i,
  input  logic               RDY_count_value,
  input  logic [VALUE_W-1:0] count_value,
  output logic               EN_count_value,
  output logic [VALUE_W-1:0] value_o,
  output logic               value_valid_o,
  output logic [1:0]         pending_o,
  output logic               overflow_o,
  input  logic               clr_overflow_i
);

  localparam int DCW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RCW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [DCW-1:0] D_LAST = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCW-1:0] R_LAST = RCW'(REPEAT_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic           r_sync1;
  logic           r_sync2;
  logic           r_db;
  logic           r_db_d;
  logic [DCW-1:0] r_dcnt;
  logic [RCW-1:0] r_rep;
  logic [1:0]     r_pend;
  logic           r_ovf;
  logic [1:0]     r_state;
  logic [VALUE_W-1:0] r_val;
  logic           r_vv;

  logic w_rise;
  logic w_req;
  logic w_issue;
  logic w_drop;

  assign w_rise  = r_db & ~r_db_d;
  assign w_req   = w_rise | (r_db & (r_rep == R_LAST));
  assign w_issue = (r_state == S_ISSUE) & RDY_count_value;
  assign w_drop  = w_req & ~w_issue & (r_pend == 2'd3);

  assign EN_count_value = w_issue;
  assign value_o        = r_val;
  assign value_valid_o  = r_vv;
  assign pending_o      = r_pend;
  assign overflow_o     = r_ovf;

  // two-flop synchroniser for the raw button
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_i;
      r_sync2 <= r_sync1;
    end
  end

  // accept a level change only after it has been stable long enough
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_db   <= 1'b0;
      r_dcnt <= '0;
    end else if (r_sync2 != r_db) begin
      if (r_dcnt == D_LAST) begin
        r_db   <= r_sync2;
        r_dcnt <= '0;
      end else begin
        r_dcnt <= r_dcnt + 1'b1;
      end
    end else begin
      r_dcnt <= '0;
    end
  end

  // press edge detect and auto-repeat timer while held
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_db_d <= 1'b0;
      r_rep  <= '0;
    end else begin
      r_db_d <= r_db;
      if (w_rise) begin
        r_rep <= '0;
      end else if (r_db) begin
        r_rep <= (r_rep == R_LAST) ? '0 : r_rep + 1'b1;
      end else begin
        r_rep <= '0;
      end
    end
  end

  // saturating count of requests not yet issued
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pend <= 2'd0;
    end else begin
      unique case ({w_req, w_issue})
        2'b10:   if (r_pend != 2'd3) r_pend <= r_pend + 2'd1;
        2'b01:   r_pend <= r_pend - 2'd1;
        default: r_pend <= r_pend;
      endcase
    end
  end

  // sticky drop flag; a drop beats a coincident clear
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (clr_overflow_i) begin
      r_ovf <= 1'b0;
    end
  end

  // issue sequencer: wait for work, call when ready, one dead cycle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (r_pend != 2'd0) r_state <= S_ISSUE;
        S_ISSUE: if (RDY_count_value) r_state <= S_GAP;
        S_GAP:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // capture the method's return value on each call
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_val <= '0;
      r_vv  <= 1'b0;
    end else begin
      r_vv <= w_issue;
      if (w_issue) r_val <= count_value;
    end
  end

endmodule

// File: tb/tb_kami_step_issuer.sv
// tb_kami_step_issuer: random and directed stimulus against a
// timing-rule reference model, with a value scoreboard.
module tb_kami_step_issuer;

  localparam int D = 4;
  localparam int R = 20;
  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         btn_i = 1'b0;
  logic         RDY = 1'b0;
  logic         clr = 1'b0;
  logic [W-1:0] cv = '0;
  logic         EN;
  logic [W-1:0] value_o;
  logic         value_valid_o;
  logic [1:0]   pending_o;
  logic         overflow_o;

  kami_step_issuer #(
    .VALUE_W(W),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_CYCLES(R)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .btn_i(btn_i),
    .RDY_count_value(RDY),
    .count_value(cv),
    .EN_count_value(EN),
    .value_o(value_o),
    .value_valid_o(value_valid_o),
    .pending_o(pending_o),
    .overflow_o(overflow_o),
    .clr_overflow_i(clr)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  bit rand_cv = 1'b1;

  always @(posedge CLK) begin
    #1;
    if (rand_cv) cv = W'($urandom);
  end

  // reference model state, valid for the current cycle
  bit           m_pipe[$];
  bit           m_db;
  int           m_run;
  int           m_held;
  int           m_pend;
  bit           m_ovf;
  bit           m_wait;
  int           m_free;
  bit           m_vv;
  logic [W-1:0] sb[$];
  int           cyc_n = 0;
  int           en_cnt = 0;
  int           last_en = -1;
  int           db_rises = 0;

  always @(negedge CLK) begin : model
    bit s, req, iss, nw, drop, dbn;
    cyc_n++;
    if (RST) begin
      m_pipe = '{1'b0, 1'b0};
      m_db = 0; m_run = 0; m_held = 0;
      m_pend = 0; m_ovf = 0; m_wait = 0;
      m_free = 0; m_vv = 0; last_en = -1;
      sb.delete();
    end
    iss = m_wait && RDY && !RST;
    chk("en", int'(EN), int'(iss));
    chk("pending", int'(pending_o), m_pend);
    chk("overflow", int'(overflow_o), int'(m_ovf));
    chk("vvalid", int'(value_valid_o), int'(m_vv));
    chk("btn_db", int'(dut.r_db), int'(m_db));
    if (EN) begin
      en_cnt++;
      if (last_en >= 0) chk("en_spacing", int'(cyc_n - last_en >= 3), 1);
      last_en = cyc_n;
    end
    if (!RST) begin
      s = m_pipe[0];
      req = m_db && (m_held % R == 0);
      if (iss) sb.push_back(cv);
      if (m_wait) nw = !RDY;
      else nw = (cyc_n >= m_free) && (m_pend > 0);
      if (iss) m_free = cyc_n + 2;
      drop = 0;
      if (req && !iss) begin
        if (m_pend == 3) drop = 1;
        else m_pend++;
      end else if (iss && !req) begin
        m_pend--;
      end
      if (drop) m_ovf = 1;
      else if (clr) m_ovf = 0;
      m_vv = iss;
      dbn = m_db;
      if (s != m_db) begin
        m_run++;
        if (m_run == D) begin
          dbn = s;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_held = dbn ? (m_db ? m_held + 1 : 0) : 0;
      if (dbn && !m_db) db_rises++;
      m_db = dbn;
      m_pipe.push_back(btn_i);
      void'(m_pipe.pop_front());
      m_wait = nw;
    end
  end

  // scoreboard monitor: every value update must match a recorded call
  always @(negedge CLK) begin
    if (value_valid_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL value_unexpected: got %0d expected none", value_o);
      end else begin
        chk("value", int'(value_o), int'(sb.pop_front()));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic press(input int hi, input int lo);
    btn_i = 1'b1;
    cyc(hi);
    btn_i = 1'b0;
    cyc(lo);
  endtask

  int e0;
  int r0;

  initial begin
    cyc(3);
    chk("rst_value", int'(value_o), 0);
    chk("rst_pending", int'(pending_o), 0);
    RST = 1'b0;
    cyc(2);

    // clean press
    rand_cv = 1'b0;
    cv = 4'h5;
    RDY = 1'b1;
    e0 = en_cnt;
    press(10, 20);
    chk("t1_en_count", en_cnt - e0, 1);
    chk("t1_value", int'(value_o), 5);
    chk("t1_pending", int'(pending_o), 0);
    rand_cv = 1'b1;

    // bounce
    e0 = en_cnt;
    r0 = db_rises;
    for (int i = 0; i < 8; i++) begin
      btn_i = ~btn_i;
      cyc(2);
    end
    btn_i = 1'b0;
    cyc(15);
    chk("t2_db_rises", db_rises - r0, 0);
    chk("t2_en_count", en_cnt - e0, 0);

    // not ready
    RDY = 1'b0;
    e0 = en_cnt;
    press(10, 30);
    chk("t3_en_held", en_cnt - e0, 0);
    chk("t3_pending", int'(pending_o), 1);
    RDY = 1'b1;
    #1;
    chk("t3_en_now", int'(EN), 1);
    cyc(5);
    chk("t3_en_count", en_cnt - e0, 1);
    chk("t3_pending0", int'(pending_o), 0);

    // auto-repeat
    e0 = en_cnt;
    r0 = db_rises;
    btn_i = 1'b1;
    for (int k = 0; k < 30 && db_rises == r0; k++) cyc(1);
    chk("t4_db_rose", db_rises - r0, 1);
    cyc(70);
    btn_i = 1'b0;
    cyc(30);
    chk("t4_en_count", en_cnt - e0, 4);

    // overflow
    RDY = 1'b0;
    e0 = en_cnt;
    for (int i = 0; i < 4; i++) press(10, 12);
    chk("t5_pending", int'(pending_o), 3);
    chk("t5_overflow", int'(overflow_o), 1);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    cyc(1);
    chk("t5_ovf_clr", int'(overflow_o), 0);
    RDY = 1'b1;
    cyc(15);
    chk("t5_en_count", en_cnt - e0, 3);
    chk("t5_pending0", int'(pending_o), 0);

    // reset while waiting in ISSUE
    RDY = 1'b0;
    press(10, 15);
    chk("t6_pending", int'(pending_o), 1);
    #3;
    RST = 1'b1;
    #1;
    chk("t6_en", int'(EN), 0);
    chk("t6_value", int'(value_o), 0);
    chk("t6_vvalid", int'(value_valid_o), 0);
    chk("t6_pend", int'(pending_o), 0);
    chk("t6_ovf", int'(overflow_o), 0);
    cyc(2);
    RST = 1'b0;
    RDY = 1'b1;
    e0 = en_cnt;
    cyc(20);
    chk("t6_no_en", en_cnt - e0, 0);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) btn_i = ~btn_i;
      RDY = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      cyc(1);
    end
    btn_i = 1'b0;
    clr = 1'b0;
    RDY = 1'b1;
    cyc(60);
    chk("drain_sb", sb.size(), 0);
    chk("drain_pending", int'(pending_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/kami_step_issuer.md
# kami_step_issuer

Input-side companion to the icestick counter top: turns a raw push-button into single-cycle method calls on a Kami/Bluespec counter's `count_value` action-value method (the `EN_count_value` / `RDY_count_value` / `count_value` triple). The LED top only drives outputs from a free-running counter. This block is the caller on the other end of that method interface. It synchronises and debounces the button, generates step requests (single press plus auto-repeat while held), queues up to three, and issues them only when the method is ready. It latches each returned value for display or logging.

## Interface
Parameters:
- `VALUE_W`, default 4: width of `count_value`/`value_o`.
- `DEBOUNCE_CYCLES`, default 12000 (1 ms at 12 MHz): consecutive stable cycles required to accept a button level change; must be ≥2.
- `REPEAT_CYCLES`, default 6000000 (0.5 s): auto-repeat period while the button stays held; must be ≥2.

Ports:
- `CLK`  in  1  single clock; all state on its rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `btn_i`  in  1  raw, asynchronous, bouncing button, active-high.
- `RDY_count_value`  in  1  callee ready for the method.
- `count_value`  in  VALUE_W  method return value, valid in the cycle `EN_count_value` is high.
- `EN_count_value`  out  1  method enable; high for exactly one cycle per call.
- `value_o`  out  VALUE_W  last returned value.
- `value_valid_o`  out  1  one-cycle pulse when `value_o` updates.
- `pending_o`  out  2  queued, not-yet-issued requests (0..3).
- `overflow_o`  out  1  sticky: a request was dropped because the queue was full.
- `clr_overflow_i`  in  1  synchronous clear of `overflow_o`.

## Operation
- **Synchroniser:** 2-flop synchroniser on `btn_i` produces `btn_s`. Nothing else samples `btn_i`.
- **Debounce:**
  - Counter increments each cycle `btn_s != btn_db`. It clears whenever they are equal.
  - On the cycle the counter equals `DEBOUNCE_CYCLES-1` with `btn_s` still differing: `btn_db <= btn_s` and the counter clears.
- **Request generation:**
  - A rising edge of `btn_db` raises one request and loads the repeat counter with 0.
  - While `btn_db`=1, the repeat counter increments. Reaching `REPEAT_CYCLES-1` raises a request and wraps to 0.
  - A falling edge of `btn_db` raises no request.
- **Queue:**
  - `pending` is a 2-bit saturating counter.
  - Request and issue in the same cycle leave it unchanged.
  - A request while `pending`=3 with no simultaneous issue is dropped and sets `overflow_o`.
  - `overflow_o` clears when `clr_overflow_i` is high. If a drop and the clear coincide, set wins.
- **Issue FSM (IDLE, ISSUE, GAP):**
  - IDLE: go to ISSUE if `pending`≠0.
  - ISSUE:
    - `EN_count_value = RDY_count_value`, combinational from state and RDY.
    - On a cycle with RDY=1: `value_o <= count_value`, `value_valid_o` pulses next cycle, `pending` decrements, go to GAP.
    - With RDY=0: stay in ISSUE indefinitely.
  - GAP: go to IDLE unconditionally. This is one dead cycle so the callee's RDY/state can settle before the next call.
  - `EN_count_value` is never high outside ISSUE.

## Timing
- **Reset values:** `EN_count_value`=0, `value_o`=0, `value_valid_o`=0, `pending_o`=0, `overflow_o`=0. Also FSM=IDLE, `btn_db`=0, synchroniser and counters 0.
- **Mid-operation reset:** asserting `RST` in ISSUE drops `EN_count_value` immediately, with no further call. Queued requests are discarded.
- **Request-to-call latency:**
  - Request raised in cycle t gives `pending_o`=1 at t+1 and ISSUE at t+2.
  - With RDY high, `EN_count_value` is high in t+2, `value_valid_o` is high in t+3, and the FSM returns to IDLE at t+4.
- **Throughput:** maximum call rate is 1 per 3 cycles.
- **Button latency:** a clean press reaches `btn_db` after 2 + `DEBOUNCE_CYCLES` cycles.
- **Glitch rejection:** any glitch shorter than `DEBOUNCE_CYCLES` cycles produces no request.

## Test plan
Benches override `DEBOUNCE_CYCLES`=4, `REPEAT_CYCLES`=20, `VALUE_W`=4.
1. **Clean press:** `btn_i` high for 10 cycles then low, RDY=1, `count_value`=4'h5. Required: exactly one `EN_count_value` pulse, `value_o`=5, one `value_valid_o` pulse, `pending_o` back to 0.
2. **Bounce:** `btn_i` toggles every 2 cycles for 16 cycles then stays low. Required: `btn_db` never rises, zero EN pulses.
3. **Not ready:** RDY=0, press once, wait 30 cycles. Required: EN stays 0 and `pending_o`=1. Then RDY=1. Required: exactly one EN pulse within 1 cycle, `pending_o`=0.
4. **Auto-repeat:** RDY=1, `btn_i` held 70 cycles after `btn_db` rises. Required: 4 EN pulses (initial plus repeats at +20/+40/+60), each pulse separated by ≥3 cycles.
5. **Overflow:** RDY=0, four separate clean presses. Required: `pending_o`=3, `overflow_o`=1. Then `clr_overflow_i` pulse. Required: `overflow_o`=0. Then RDY=1. Required: exactly 3 EN pulses.
6. **Reset in ISSUE:** FSM in ISSUE with RDY=0, assert RST mid-cycle. Required: EN=0 immediately, all outputs at reset values. No EN after release with RDY=1.
